test_monitor: RTL and testbench

Parametrised verification-harness monitor for the CI simulation top. It sequences the shared `reset` for NUM_TESTS test instances, then collects their per-test `fail`/`finish` strobes into sticky masks. It reports a single verdict (pass, fail with first failing index, or timeout) so the bench can stop on one signal. It replaces hand-sized `fail`/`finish` vectors and inline `|fail` / `&finish` checks in the simulation top.

---
 rtl/test_monitor_pkg.sv | 22 ++
 rtl/test_monitor_prio_enc.sv | 29 ++
 rtl/test_monitor.sv | 115 +++++++++++
 tb/tb_test_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/test_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : test_monitor_pkg
// Purpose  : Shared state encoding and default constants for test_monitor.
// Revision : 1.0 - initial release
// ============================================================================
package test_monitor_pkg;

    // Monitor life cycle: reset sequencing, live collection, then one verdict
    typedef enum logic [2:0] {
        HOLD         = 3'd0,
        RUN          = 3'd1,
        DONE_PASS    = 3'd2,
        DONE_FAIL    = 3'd3,
        DONE_TIMEOUT = 3'd4
    } tm_state_t;

    localparam int c_reset_cycles_default = 16;
    localparam int c_timeout_default      = 100000;

endpackage : test_monitor_pkg
`default_nettype wire

// File: rtl/test_monitor_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : test_monitor_prio_enc
// Purpose  : Combinational lowest-set-bit encoder with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module test_monitor_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : test_monitor_prio_enc
`default_nettype wire

// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_monitor
// Purpose  : Sequences the shared test reset, collects sticky fail/finish
//            masks from NUM_TESTS instances and registers a single verdict.
// Options  : TEST_MONITOR_WATCHDOG_EN - enables the RUN-cycle timeout verdict.
// Revision : 1.0 - initial release
// ============================================================================
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int NUM_TESTS    = 42,
    parameter int RESET_CYCLES = c_reset_cycles_default,
    parameter int TIMEOUT      = c_timeout_default,
    parameter int IDX_W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_TESTS-1:0] fail,
    input  logic [NUM_TESTS-1:0] finish,
    output logic                 test_reset,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [IDX_W-1:0]     fail_index,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] finish_mask,
    output logic [CNT_W-1:0]     cycle_count
);

    tm_state_t  r_state;
    logic [31:0] r_hold_cnt;

    logic [IDX_W-1:0] w_fail_idx;
    logic             w_fail_any;
    logic             w_all_finished;
    logic             w_cnt_sat;

    test_monitor_prio_enc #(
        .N (NUM_TESTS),
        .W (IDX_W)
    ) u_prio_enc (
        .req   (fail),
        .idx   (w_fail_idx),
        .valid (w_fail_any)
    );

    // Include this cycle's strobes so the last finish is recognised immediately
    assign w_all_finished = &(finish_mask | finish);
    assign w_cnt_sat      = (cycle_count == {CNT_W{1'b1}});

`ifndef TEST_MONITOR_WATCHDOG_EN
    // The budget is meaningless without the watchdog; keep it referenced
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT != 0);
`endif

    // Monitor state machine with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= HOLD;
            r_hold_cnt  <= '0;
            test_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_index  <= '0;
            fail_mask   <= '0;
            finish_mask <= '0;
            cycle_count <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    // Strobes from instances still under reset are ignored
                    r_hold_cnt <= r_hold_cnt + 32'd1;
                    if (r_hold_cnt == 32'(RESET_CYCLES - 1)) begin
                        r_state    <= RUN;
                        test_reset <= 1'b0;
                    end
                end
                RUN: begin
                    test_reset  <= 1'b0;
                    fail_mask   <= fail_mask | fail;
                    finish_mask <= finish_mask | finish;
                    if (!w_cnt_sat) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    // A failure outranks a simultaneous final finish
                    if (w_fail_any) begin
                        r_state    <= DONE_FAIL;
                        done       <= 1'b1;
                        fail_index <= w_fail_idx;
                    end else if (w_all_finished) begin
                        r_state <= DONE_PASS;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end
`ifdef TEST_MONITOR_WATCHDOG_EN
                    else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
                        r_state <= DONE_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
`endif
                end
                default: begin
                    // Verdict states are terminal; everything stays frozen
                end
            endcase
        end
    end

endmodule : test_monitor
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_monitor
// Purpose  : Self-checking bench for test_monitor (4 tests, 16 hold cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_monitor;

    localparam int c_n   = 4;
    localparam int c_rc  = 16;
    localparam int c_to  = 100;
    localparam int c_idx = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [c_n-1:0]  fail = '0;
    logic [c_n-1:0]  finish = '0;
    logic            test_reset;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [c_idx-1:0] fail_index;
    logic [c_n-1:0]  fail_mask;
    logic [c_n-1:0]  finish_mask;
    logic [31:0]     cycle_count;

    int errors = 0;
    int checks = 0;

    test_monitor #(
        .NUM_TESTS    (c_n),
        .RESET_CYCLES (c_rc),
        .TIMEOUT      (c_to),
        .CNT_W        (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fail        (fail),
        .finish      (finish),
        .test_reset  (test_reset),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_index  (fail_index),
        .fail_mask   (fail_mask),
        .finish_mask (finish_mask),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  fail;
        logic [3:0]  finish;
        logic        done;
        logic        pass;
        logic [3:0]  fail_mask;
        logic [3:0]  finish_mask;
        logic [31:0] cycle_count;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".test_reset"}, 32'(test_reset), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
        check({tag, ".fail_index"}, 32'(fail_index), 32'd0);
        check({tag, ".fail_mask"}, 32'(fail_mask), 32'd0);
        check({tag, ".finish_mask"}, 32'(finish_mask), 32'd0);
        check({tag, ".cycle_count"}, cycle_count, 32'd0);
    endtask

    // One reset cycle, then the full hold period so the next edge is RUN cycle 1
    task automatic restart();
        fail   = '0;
        finish = '0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < c_rc; i++) step();
        check("restart.test_reset", 32'(test_reset), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 32'd1};
        vecs[1] = '{4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0101, 32'd2};
        vecs[2] = '{4'b0000, 4'b1010, 1'b1, 1'b1, 4'b0000, 4'b1111, 32'd3};
        vecs[3] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1111, 32'd3};
        vecs[4] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1111, 32'd3};

        // Reset sequencing with fail strobes asserted throughout
        reset = 1'b1;
        fail  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_values("rst");
        end
        reset = 1'b0;
        for (int k = 1; k <= c_rc; k++) begin
            step();
            check("hold.test_reset", 32'(test_reset), (k < c_rc) ? 32'd1 : 32'd0);
            check("hold.fail_mask", 32'(fail_mask), 32'd0);
            check("hold.done", 32'(done), 32'd0);
        end
        fail = '0;

        // Staggered finish, then frozen verdict
        for (int v = 0; v < 5; v++) begin
            fail   = vecs[v].fail;
            finish = vecs[v].finish;
            step();
            check("vec.done", 32'(done), 32'(vecs[v].done));
            check("vec.pass", 32'(pass), 32'(vecs[v].pass));
            check("vec.timeout", 32'(timeout), 32'd0);
            check("vec.fail_mask", 32'(fail_mask), 32'(vecs[v].fail_mask));
            check("vec.finish_mask", 32'(finish_mask), 32'(vecs[v].finish_mask));
            check("vec.cycle_count", cycle_count, vecs[v].cycle_count);
        end

        // Fail on RUN cycle 5
        restart();
        for (int i = 0; i < 4; i++) step();
        check("fail.pre_done", 32'(done), 32'd0);
        fail = 4'b1010;
        step();
        fail = '0;
        check("fail.done", 32'(done), 32'd1);
        check("fail.pass", 32'(pass), 32'd0);
        check("fail.timeout", 32'(timeout), 32'd0);
        check("fail.fail_index", 32'(fail_index), 32'd1);
        check("fail.fail_mask", 32'(fail_mask), 32'b1010);
        check("fail.cycle_count", cycle_count, 32'd5);
        step();
        check("fail.frozen_count", cycle_count, 32'd5);
        check("fail.frozen_index", 32'(fail_index), 32'd1);

        // Final finish coincides with a fail: fail wins
        restart();
        finish = 4'b0111;
        step();
        check("simul.pre_mask", 32'(finish_mask), 32'b0111);
        finish = 4'b1000;
        fail   = 4'b1000;
        step();
        finish = '0;
        fail   = '0;
        check("simul.done", 32'(done), 32'd1);
        check("simul.pass", 32'(pass), 32'd0);
        check("simul.fail_index", 32'(fail_index), 32'd3);
        check("simul.fail_mask", 32'(fail_mask), 32'b1000);
        check("simul.finish_mask", 32'(finish_mask), 32'hF);

        // Reset mid-RUN restarts the full hold period
        restart();
        finish = 4'b0011;
        step();
        check("midrst.finish_mask", 32'(finish_mask), 32'b0011);
        finish = '0;
        reset  = 1'b1;
        step();
        check_reset_values("midrst");
        reset  = 1'b0;
        finish = 4'hF;
        for (int k = 1; k <= c_rc; k++) begin
            step();
            check("midrst.test_reset", 32'(test_reset), (k < c_rc) ? 32'd1 : 32'd0);
        end
        check("midrst.hold_mask", 32'(finish_mask), 32'd0);
        check("midrst.hold_done", 32'(done), 32'd0);
        finish = '0;

        // Watchdog behaviour with no strobes
        restart();
`ifdef TEST_MONITOR_WATCHDOG_EN
        for (int i = 0; i < c_to - 1; i++) step();
        check("wd.pre_done", 32'(done), 32'd0);
        check("wd.pre_count", cycle_count, 32'(c_to - 1));
        step();
        check("wd.done", 32'(done), 32'd1);
        check("wd.timeout", 32'(timeout), 32'd1);
        check("wd.pass", 32'(pass), 32'd0);
        check("wd.count", cycle_count, 32'(c_to));
        step();
        check("wd.frozen_count", cycle_count, 32'(c_to));
`else
        for (int i = 0; i < 1000; i++) step();
        check("nowd.done", 32'(done), 32'd0);
        check("nowd.timeout", 32'(timeout), 32'd0);
        check("nowd.count", cycle_count, 32'd1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_test_monitor
`default_nettype wire
